// File: rtl/tron_player_mover.sv
// Steps one light-cycle head per prescaler tick and hands each new pixel to the plot stage over req/ack.
// Stops in a terminal crash state on a wall hit or when the plot stage reports an occupied pixel.
module tron_player_mover #(
  parameter int          X_MAX     = 160,
  parameter int          Y_MAX     = 120,
  parameter int          X_START   = 8,
  parameter int          Y_START   = 60,
  parameter logic [4:0]  START_DIR = 5'b00010,
  parameter int          TICK_DIV  = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] dir_in,
  input  logic       hit_in,
  input  logic       plot_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [4:0] heading,
  output logic       plot_req,
  output logic       crashed
);

  localparam logic [4:0] D_UP = 5'b10000;
  localparam logic [4:0] D_DN = 5'b01000;
  localparam logic [4:0] D_LF = 5'b00100;
  localparam logic [4:0] D_RT = 5'b00010;

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_CRASH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    pending;
  logic          step;
  logic          dir_ok;
  logic          wall;
  logic [7:0]    x_nxt;
  logic [6:0]    y_nxt;

  function automatic logic [4:0] opposite(input logic [4:0] d);
    case (d)
      D_UP:    opposite = D_DN;
      D_DN:    opposite = D_UP;
      D_LF:    opposite = D_RT;
      default: opposite = D_LF;
    endcase
  endfunction

  always_comb begin
    dir_ok = (dir_in inside {D_UP, D_DN, D_LF, D_RT}) && (dir_in != opposite(heading));
    step   = (state == S_IDLE) && enable && (cnt == TICK_LAST);
  end

  // Wall check comes before the move so the head never wraps.
  always_comb begin
    wall  = 1'b0;
    x_nxt = x;
    y_nxt = y;
    case (pending)
      D_UP: if (y == 7'd0) wall = 1'b1;
            else y_nxt = y - 7'd1;
      D_DN: if (y == 7'(Y_MAX - 1)) wall = 1'b1;
            else y_nxt = y + 7'd1;
      D_LF: if (x == 8'd0) wall = 1'b1;
            else x_nxt = x - 8'd1;
      default: if (x == 8'(X_MAX - 1)) wall = 1'b1;
               else x_nxt = x + 8'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_PLOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (step) state_nxt = wall ? S_CRASH : S_PLOT;
      S_PLOT:  if (plot_ack) state_nxt = hit_in ? S_CRASH : S_IDLE;
      default: state_nxt = S_CRASH;
    endcase
  end

  always_comb begin
    plot_req = (state == S_PLOT);
    crashed  = (state == S_CRASH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= 8'(X_START);
      y       <= 7'(Y_START);
      heading <= START_DIR;
      pending <= START_DIR;
      cnt     <= '0;
    end else begin
      if (state != S_CRASH && dir_ok) pending <= dir_in;
      // Prescaler only runs while idle; PLOT and CRASH freeze the count.
      if (state == S_IDLE && enable) cnt <= (cnt == TICK_LAST) ? '0 : cnt + CW'(1);
      if (step) begin
        heading <= pending;
        x       <= x_nxt;
        y       <= y_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tron_player_mover.sv
// Bench for tron_player_mover: direction table, reversal blocking, self-hit, reset, enable hold and all four walls.
module tb_tron_player_mover;

  localparam logic [4:0] UP = 5'b10000;
  localparam logic [4:0] DN = 5'b01000;
  localparam logic [4:0] LF = 5'b00100;
  localparam logic [4:0] RT = 5'b00010;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] dir_in = 5'd0;
  logic       hit_in = 1'b0;
  logic       plot_ack = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [4:0] heading;
  logic       plot_req;
  logic       crashed;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] d1;
    logic [4:0] d2;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [4:0] eh;
    logic       ec;
  } vec_t;

  typedef struct {
    logic [7:0] ex;
    logic [6:0] ey;
    logic [4:0] eh;
    logic       ec;
  } exp_t;

  exp_t sbq[$];

  tron_player_mover #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in), .hit_in(hit_in),
    .plot_ack(plot_ack), .x(x), .y(y), .heading(heading), .plot_req(plot_req), .crashed(crashed)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0; plot_ack = 1'b0; hit_in = 1'b0; dir_in = 5'd0; enable = 1'b1;
    sbq.delete();
    chk({tag, "_x"}, x, 8);
    chk({tag, "_y"}, y, 60);
    chk({tag, "_heading"}, heading, RT);
    chk({tag, "_plot_req"}, plot_req, 1);
    chk({tag, "_crashed"}, crashed, 0);
  endtask

  // Plot must stay stable until acked.
  task automatic hold2(input string tag, input int ex, input int ey);
    tick(); tick();
    chk({tag, "_hold_req"}, plot_req, 1);
    chk({tag, "_hold_x"}, x, ex);
    chk({tag, "_hold_y"}, y, ey);
  endtask

  // Ack the outstanding plot, press d1 then d2 during the idle tick, then check the next plot.
  task automatic run_vec(input string tag, input vec_t v);
    int   n;
    exp_t e;
    plot_ack = 1'b1; hit_in = 1'b0;
    tick();
    plot_ack = 1'b0;
    dir_in = v.d1;
    tick();
    dir_in = v.d2;
    tick();
    dir_in = 5'd0;
    sbq.push_back('{ex: v.ex, ey: v.ey, eh: v.eh, ec: v.ec});
    n = 2;
    while (!plot_req && !crashed && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_idle_cycles"}, n, 4);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_x"}, x, e.ex);
      chk({tag, "_y"}, y, e.ey);
      chk({tag, "_heading"}, heading, e.eh);
      chk({tag, "_crashed"}, crashed, e.ec);
      chk({tag, "_plot_req"}, plot_req, !e.ec);
      if (!e.ec) hold2(tag, e.ex, e.ey);
    end
  endtask

  // Crash is terminal: presses, acks and enable must change nothing.
  task automatic crash_hold(input string tag, input int ex, input int ey, input int eh);
    dir_in = UP; plot_ack = 1'b1; hit_in = 1'b0; enable = 1'b1;
    repeat (12) tick();
    dir_in = DN;
    repeat (8) tick();
    dir_in = 5'd0; plot_ack = 1'b0;
    chk({tag, "_ch_x"}, x, ex);
    chk({tag, "_ch_y"}, y, ey);
    chk({tag, "_ch_heading"}, heading, eh);
    chk({tag, "_ch_crashed"}, crashed, 1);
    chk({tag, "_ch_plot_req"}, plot_req, 0);
  endtask

  initial begin
    vec_t tbl[11];
    int   n;

    tbl[0]  = '{d1: 5'd0, d2: 5'd0,     ex: 8'd9,  ey: 7'd60, eh: RT, ec: 1'b0};
    tbl[1]  = '{d1: 5'd0, d2: 5'd0,     ex: 8'd10, ey: 7'd60, eh: RT, ec: 1'b0};
    tbl[2]  = '{d1: 5'd0, d2: 5'd0,     ex: 8'd11, ey: 7'd60, eh: RT, ec: 1'b0};
    tbl[3]  = '{d1: LF,   d2: UP,       ex: 8'd11, ey: 7'd59, eh: UP, ec: 1'b0};
    tbl[4]  = '{d1: DN,   d2: 5'd0,     ex: 8'd11, ey: 7'd58, eh: UP, ec: 1'b0};
    tbl[5]  = '{d1: LF,   d2: 5'd0,     ex: 8'd10, ey: 7'd58, eh: LF, ec: 1'b0};
    tbl[6]  = '{d1: RT,   d2: 5'd0,     ex: 8'd9,  ey: 7'd58, eh: LF, ec: 1'b0};
    tbl[7]  = '{d1: 5'b11000, d2: 5'b00001, ex: 8'd8, ey: 7'd58, eh: LF, ec: 1'b0};
    tbl[8]  = '{d1: DN,   d2: 5'd0,     ex: 8'd8,  ey: 7'd59, eh: DN, ec: 1'b0};
    tbl[9]  = '{d1: UP,   d2: RT,       ex: 8'd9,  ey: 7'd59, eh: RT, ec: 1'b0};
    tbl[10] = '{d1: 5'd0, d2: LF,       ex: 8'd10, ey: 7'd59, eh: RT, ec: 1'b0};

    tick();
    do_reset("rst0");
    hold2("start", 8, 60);
    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Self-hit on the plot at (10,59).
    plot_ack = 1'b1; hit_in = 1'b1;
    tick();
    plot_ack = 1'b0; hit_in = 1'b0;
    chk("selfhit_crashed", crashed, 1);
    chk("selfhit_plot_req", plot_req, 0);
    chk("selfhit_x", x, 10);
    crash_hold("selfhit", 10, 59, RT);

    // Reset mid-PLOT, coinciding with an ack carrying a hit.
    do_reset("rst1");
    for (int i = 9; i <= 12; i++)
      run_vec($sformatf("r%0d", i), '{d1: 5'd0, d2: 5'd0, ex: 8'(i), ey: 7'd60, eh: RT, ec: 1'b0});
    chk("midplot_req", plot_req, 1);
    plot_ack = 1'b1; hit_in = 1'b1;
    do_reset("rst_mid");

    // Enable low holds the prescaler at its current count.
    plot_ack = 1'b1;
    tick();
    plot_ack = 1'b0;
    tick(); tick();
    enable = 1'b0;
    repeat (20) tick();
    chk("en_hold_req", plot_req, 0);
    chk("en_hold_x", x, 8);
    enable = 1'b1;
    n = 0;
    while (!plot_req && n < 40) begin
      tick();
      n++;
    end
    chk("en_resume_cycles", n, 2);
    chk("en_resume_x", x, 9);

    // Right wall.
    do_reset("rst_rt");
    for (int i = 9; i <= 159; i++)
      run_vec("rt", '{d1: 5'd0, d2: 5'd0, ex: 8'(i), ey: 7'd60, eh: RT, ec: 1'b0});
    run_vec("rt_wall", '{d1: 5'd0, d2: 5'd0, ex: 8'd159, ey: 7'd60, eh: RT, ec: 1'b1});
    crash_hold("rt_wall", 159, 60, RT);

    // Top wall.
    do_reset("rst_up");
    for (int i = 59; i >= 0; i--)
      run_vec("up", '{d1: UP, d2: 5'd0, ex: 8'd8, ey: 7'(i), eh: UP, ec: 1'b0});
    run_vec("up_wall", '{d1: 5'd0, d2: 5'd0, ex: 8'd8, ey: 7'd0, eh: UP, ec: 1'b1});
    crash_hold("up_wall", 8, 0, UP);

    // Left wall.
    do_reset("rst_lf");
    run_vec("lf_turn", '{d1: UP, d2: 5'd0, ex: 8'd8, ey: 7'd59, eh: UP, ec: 1'b0});
    for (int i = 7; i >= 0; i--)
      run_vec("lf", '{d1: LF, d2: 5'd0, ex: 8'(i), ey: 7'd59, eh: LF, ec: 1'b0});
    run_vec("lf_wall", '{d1: 5'd0, d2: 5'd0, ex: 8'd0, ey: 7'd59, eh: LF, ec: 1'b1});

    // Bottom wall.
    do_reset("rst_dn");
    for (int i = 61; i <= 119; i++)
      run_vec("dn", '{d1: DN, d2: 5'd0, ex: 8'd8, ey: 7'(i), eh: DN, ec: 1'b0});
    run_vec("dn_wall", '{d1: 5'd0, d2: 5'd0, ex: 8'd8, ey: 7'd119, eh: DN, ec: 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
